crc_sig_capture: RTL and testbench
==================================

# crc_sig_capture

Signature accumulator downstream of the blanking/sync stage. Per pixel, it folds the latched red/green/blue DAC comparator bits into three 16-bit serial CRC MISRs while the upstream CRC window is open. On frame-end (`misr_done`) it freezes the signatures and the window pixel count into host-readable hold registers, with a valid/ack handshake and a sticky overflow flag. It sits between the sync/blank generator (which supplies `init_crc`, `enable_crc`, `misr_done` and the `l*_comp` bits) and the host register file.

## Interface
Parameters:
- `SEED`, 16'hFFFF: MISR initial value loaded on `init_crc`.
- `POLY`, 16'h1021: feedback polynomial (x^16+x^12+x^5+1).
- `COUNT_W`, 24: width of the window pixel counter.

Ports:
- `pixclk`  in  1  pixel clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `init_crc`  in  1  single-cycle MISR/counter initialise.
- `enable_crc`  in  1  CRC window; accumulate on each cycle it is high.
- `misr_done`  in  1  level from upstream; its rising edge requests capture.
- `lred_comp`, `lgrn_comp`, `lblu_comp`  in  1 each  latched comparator bits.
- `sig_ack`  in  1  host single-cycle acknowledge of a captured result.
- `sig_red`, `sig_grn`, `sig_blu`  out  16 each  captured signatures.
- `sig_count`  out  COUNT_W  captured count of accumulated pixels.
- `sig_valid`  out  1  a captured result is held and unacknowledged.
- `sig_ovf`  out  1  sticky: a capture overwrote an unacknowledged result.
- `busy`  out  1  accumulation armed (set by `init_crc`, cleared on capture).

## Operation
- Per-channel MISR update for channel bit `d`:
  - `fb = crc[15] ^ d`
  - `crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 16'h0)`
- Live state: `crc_r`, `crc_g`, `crc_b` (16 bits each) and `cnt` (COUNT_W bits).
- Priority, evaluated every cycle:
  - `init_crc`=1: all three MISRs <= SEED, `cnt` <= 0, `busy` <= 1. This overrides `enable_crc` in the same cycle.
  - Else if `enable_crc`=1: all three MISRs update with their channel bit. `cnt` <= `cnt`+1, saturating at all-ones.
  - Else: hold.
- Capture trigger: `done_d` is `misr_done` registered once. A capture fires when `misr_done & !done_d`.
- On capture:
  - Hold registers <= live `crc_r`/`crc_g`/`crc_b`/`cnt`, taken after that cycle's update is applied.
  - `sig_valid` <= 1 and `busy` <= 0.
  - If `sig_valid`=1 and `sig_ack`=0 in the capture cycle, `sig_ovf` <= 1.
- `sig_ack`:
  - Clears `sig_valid` and `sig_ovf`.
  - If a capture occurs in the same cycle, the capture wins: `sig_valid` stays 1, hold registers take the new data, and `sig_ovf` is cleared (ack consumed the old result).
  - `sig_ack` while `sig_valid`=0 has no effect.
- Live MISRs are never cleared by capture or ack, only by `init_crc` or reset.
- A `misr_done` level held high produces exactly one capture. Re-arming requires a low cycle.

## Timing
- Reset (async, `reset`=0) clears all of the following:
  - live MISRs = SEED
  - `cnt` = 0
  - `done_d` = 0
  - `sig_red`/`sig_grn`/`sig_blu` = 16'h0000
  - `sig_count` = 0
  - `sig_valid` = 0, `sig_ovf` = 0, `busy` = 0
- Reset mid-frame discards the live accumulation and any held result.
- Accumulate latency: a comparator bit sampled at edge N is reflected in live MISR after edge N. Hold registers see it only via a capture.
- Capture latency: `misr_done` rising before edge N is detected at edge N. Outputs update after edge N+1, and `sig_valid` rises after edge N+1.
- Upstream drops `enable_crc` on the same edge that raises `misr_done`. The pixel at that edge is therefore excluded, and no pixels are lost between the last enable and the capture.
- Ack to `sig_valid` low: 1 cycle.
- Counter saturation: at `cnt` = 2^COUNT_W−1, further enabled cycles hold `cnt` while the MISRs keep updating.

## Test plan
- Reset release, then `init_crc` for 1 cycle, then 1 enabled cycle with r=1, g=0, b=0 -> live `crc_r`=16'hFFFE, `crc_g`=`crc_b`=16'hEFDF. Pulse `misr_done` -> after 2 edges, `sig_red`=FFFE, `sig_grn`=`sig_blu`=EFDF, `sig_count`=1, `sig_valid`=1, `busy`=0.
- `init_crc` and `enable_crc` both high in the same cycle with r=g=b=0 -> MISRs = FFFF, `cnt`=0 (init wins). Next enabled cycle with 0s -> all EFDF, `cnt`=1.
- Two captures without ack -> `sig_ovf`=1 after the second, and hold registers show the second frame. `sig_ack` -> `sig_valid`=0, `sig_ovf`=0 one cycle later.
- `sig_ack` coincident with a capture edge while `sig_valid`=1 -> `sig_valid` stays 1, `sig_ovf`=0, hold registers take the new data.
- `misr_done` held high for 10 cycles -> exactly one capture. Drop it, raise it again -> second capture.
- COUNT_W=4, 20 enabled cycles after init -> `sig_count`=15. MISR matches a reference model over all 20 bits. Assert `reset` low mid-window -> all outputs at reset values immediately.

Source files
------------

// File: rtl/crc_sig_capture.sv
// rtl/crc_sig_capture.sv - per-channel 16-bit CRC MISR signature capture with host hold registers
module crc_sig_capture #(
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [15:0] POLY    = 16'h1021,
    parameter int          COUNT_W = 24
) (
    input  logic               pixclk,
    input  logic               reset,
    input  logic               init_crc,
    input  logic               enable_crc,
    input  logic               misr_done,
    input  logic               lred_comp,
    input  logic               lgrn_comp,
    input  logic               lblu_comp,
    input  logic               sig_ack,
    output logic [15:0]        sig_red,
    output logic [15:0]        sig_grn,
    output logic [15:0]        sig_blu,
    output logic [COUNT_W-1:0] sig_count,
    output logic               sig_valid,
    output logic               sig_ovf,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [15:0]        crc_r;
    logic [15:0]        crc_g;
    logic [15:0]        crc_b;
    logic [COUNT_W-1:0] cnt;
    logic               done_d;
    logic               cap_q;

    // One serial MISR step: shift left, fold in the polynomial when feedback is set.
    function automatic logic [15:0] misr_next(input logic [15:0] crc, input logic d);
        logic fb;
        fb = crc[15] ^ d;
        return {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    // Live accumulation: init beats enable; counter saturates while MISRs keep running.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            crc_r <= SEED;
            crc_g <= SEED;
            crc_b <= SEED;
            cnt   <= '0;
        end else if (init_crc) begin
            crc_r <= SEED;
            crc_g <= SEED;
            crc_b <= SEED;
            cnt   <= '0;
        end else if (enable_crc) begin
            crc_r <= misr_next(crc_r, lred_comp);
            crc_g <= misr_next(crc_g, lgrn_comp);
            crc_b <= misr_next(crc_b, lblu_comp);
            if (cnt != '1) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Rising-edge detect on misr_done; the detected pulse loads the hold registers one edge later,
    // by which point the live state already contains the last enabled pixel.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            done_d <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            done_d <= misr_done;
            cap_q  <= misr_done & ~done_d;
        end
    end

    // Host-facing hold registers with valid/ack handshake; a capture beats a coincident ack.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            sig_red   <= 16'h0000;
            sig_grn   <= 16'h0000;
            sig_blu   <= 16'h0000;
            sig_count <= '0;
            sig_valid <= 1'b0;
            sig_ovf   <= 1'b0;
        end else if (cap_q) begin
            sig_red   <= crc_r;
            sig_grn   <= crc_g;
            sig_blu   <= crc_b;
            sig_count <= cnt;
            sig_valid <= 1'b1;
            if (sig_ack) begin
                sig_ovf <= 1'b0;
            end else if (sig_valid) begin
                sig_ovf <= 1'b1;
            end
        end else if (sig_ack) begin
            sig_valid <= 1'b0;
            sig_ovf   <= 1'b0;
        end
    end

    // Armed from init until the next capture; init wins if both land on one edge.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
        end else if (init_crc) begin
            busy <= 1'b1;
        end else if (cap_q) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc_sig_capture.sv
// tb/tb_crc_sig_capture.sv - directed self-checking bench for crc_sig_capture
module tb_crc_sig_capture;

    localparam int CW = 4;

    logic          pixclk;
    logic          reset;
    logic          init_crc;
    logic          enable_crc;
    logic          misr_done;
    logic          lred_comp;
    logic          lgrn_comp;
    logic          lblu_comp;
    logic          sig_ack;
    logic [15:0]   sig_red;
    logic [15:0]   sig_grn;
    logic [15:0]   sig_blu;
    logic [CW-1:0] sig_count;
    logic          sig_valid;
    logic          sig_ovf;
    logic          busy;

    int pass_cnt;
    int total_cnt;

    logic [15:0]   mr, mg, mb;
    logic [CW-1:0] mc;
    logic [15:0]   er, eg, eb;
    logic [CW-1:0] ec;

    crc_sig_capture #(
        .SEED    (16'hFFFF),
        .POLY    (16'h1021),
        .COUNT_W (CW)
    ) dut (
        .pixclk     (pixclk),
        .reset      (reset),
        .init_crc   (init_crc),
        .enable_crc (enable_crc),
        .misr_done  (misr_done),
        .lred_comp  (lred_comp),
        .lgrn_comp  (lgrn_comp),
        .lblu_comp  (lblu_comp),
        .sig_ack    (sig_ack),
        .sig_red    (sig_red),
        .sig_grn    (sig_grn),
        .sig_blu    (sig_blu),
        .sig_count  (sig_count),
        .sig_valid  (sig_valid),
        .sig_ovf    (sig_ovf),
        .busy       (busy)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] c, input logic d);
        logic [15:0] s;
        s = c << 1;
        if (c[15] != d) s = s ^ 16'h1021;
        return s;
    endfunction

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic do_init();
        init_crc = 1'b1;
        tick();
        init_crc = 1'b0;
        mr = 16'hFFFF; mg = 16'hFFFF; mb = 16'hFFFF; mc = '0;
    endtask

    task automatic pix(input logic r, input logic g, input logic b);
        enable_crc = 1'b1;
        lred_comp = r; lgrn_comp = g; lblu_comp = b;
        tick();
        enable_crc = 1'b0;
        lred_comp = 1'b0; lgrn_comp = 1'b0; lblu_comp = 1'b0;
        mr = ref_step(mr, r);
        mg = ref_step(mg, g);
        mb = ref_step(mb, b);
        if (mc != {CW{1'b1}}) mc = mc + 1'b1;
    endtask

    // misr_done pulse; ack_at_load drives sig_ack on the edge that loads the hold registers
    task automatic capture(input logic ack_at_load);
        misr_done = 1'b1;
        tick();
        misr_done = 1'b0;
        sig_ack = ack_at_load;
        tick();
        sig_ack = 1'b0;
        er = mr; eg = mg; eb = mb; ec = mc;
    endtask

    task automatic ack();
        sig_ack = 1'b1;
        tick();
        sig_ack = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_red"}, {16'h0, sig_red}, {16'h0, er});
        check({tag, "_grn"}, {16'h0, sig_grn}, {16'h0, eg});
        check({tag, "_blu"}, {16'h0, sig_blu}, {16'h0, eb});
        check({tag, "_cnt"}, {28'h0, sig_count}, {28'h0, ec});
    endtask

    logic [19:0] pat_r, pat_g, pat_b;

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b0;
        init_crc = 1'b0; enable_crc = 1'b0; misr_done = 1'b0;
        lred_comp = 1'b0; lgrn_comp = 1'b0; lblu_comp = 1'b0;
        sig_ack = 1'b0;
        mr = 16'hFFFF; mg = 16'hFFFF; mb = 16'hFFFF; mc = '0;
        er = '0; eg = '0; eb = '0; ec = '0;

        #3;
        check("rst_red", {16'h0, sig_red}, 32'h0);
        check("rst_cnt", {28'h0, sig_count}, 32'h0);
        check("rst_valid", {31'h0, sig_valid}, 32'h0);
        check("rst_ovf", {31'h0, sig_ovf}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        #20;
        reset = 1'b1;
        tick();

        // single pixel r=1 g=0 b=0, hand-computed signatures
        do_init();
        check("init_busy", {31'h0, busy}, 32'h1);
        pix(1'b1, 1'b0, 1'b0);
        capture(1'b0);
        check("t1_red", {16'h0, sig_red}, 32'hFFFE);
        check("t1_grn", {16'h0, sig_grn}, 32'hEFDF);
        check("t1_blu", {16'h0, sig_blu}, 32'hEFDF);
        check("t1_cnt", {28'h0, sig_count}, 32'h1);
        check("t1_valid", {31'h0, sig_valid}, 32'h1);
        check("t1_busy", {31'h0, busy}, 32'h0);
        check("t1_ovf", {31'h0, sig_ovf}, 32'h0);
        ack();
        check("t1_ack_valid", {31'h0, sig_valid}, 32'h0);

        // init and enable together: init wins
        init_crc = 1'b1; enable_crc = 1'b1;
        tick();
        init_crc = 1'b0; enable_crc = 1'b0;
        mr = 16'hFFFF; mg = 16'hFFFF; mb = 16'hFFFF; mc = '0;
        capture(1'b0);
        check("t2_red", {16'h0, sig_red}, 32'hFFFF);
        check("t2_cnt", {28'h0, sig_count}, 32'h0);
        ack();
        pix(1'b0, 1'b0, 1'b0);
        capture(1'b0);
        check("t2b_red", {16'h0, sig_red}, 32'hEFDF);
        check("t2b_blu", {16'h0, sig_blu}, 32'hEFDF);
        check("t2b_cnt", {28'h0, sig_count}, 32'h1);
        check("t2b_ovf", {31'h0, sig_ovf}, 32'h0);

        // second capture without ack -> overflow, hold shows second frame
        pix(1'b1, 1'b1, 1'b0);
        capture(1'b0);
        check("t3_ovf", {31'h0, sig_ovf}, 32'h1);
        check("t3_valid", {31'h0, sig_valid}, 32'h1);
        check_hold("t3");

        // ack coincident with a capture load: capture wins, overflow cleared
        pix(1'b0, 1'b1, 1'b1);
        capture(1'b1);
        check("t4_valid", {31'h0, sig_valid}, 32'h1);
        check("t4_ovf", {31'h0, sig_ovf}, 32'h0);
        check_hold("t4");
        ack();
        check("t4_ack_valid", {31'h0, sig_valid}, 32'h0);
        check("t4_ack_ovf", {31'h0, sig_ovf}, 32'h0);

        // misr_done held high for 10 cycles: exactly one capture
        pix(1'b1, 1'b0, 1'b1);
        misr_done = 1'b1;
        tick(); tick();
        check("t5_first_valid", {31'h0, sig_valid}, 32'h1);
        er = mr; eg = mg; eb = mb; ec = mc;
        check_hold("t5");
        ack();
        for (int i = 0; i < 7; i++) tick();
        check("t5_no_recapture", {31'h0, sig_valid}, 32'h0);
        misr_done = 1'b0;
        tick();
        capture(1'b0);
        check("t5_rearm_valid", {31'h0, sig_valid}, 32'h1);
        check("t5_rearm_ovf", {31'h0, sig_ovf}, 32'h0);
        check_hold("t5b");
        ack();

        // 20 pixels against the reference model, counter saturates at 15
        pat_r = 20'hA5C3F; pat_g = 20'h3B16E; pat_b = 20'hF0F0F;
        do_init();
        for (int i = 0; i < 20; i++) pix(pat_r[i], pat_g[i], pat_b[i]);
        capture(1'b0);
        check("t6_cnt_sat", {28'h0, sig_count}, 32'hF);
        check_hold("t6");

        // reset mid-window clears outputs without a clock edge
        do_init();
        enable_crc = 1'b1; lred_comp = 1'b1;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        check("t7_red", {16'h0, sig_red}, 32'h0);
        check("t7_grn", {16'h0, sig_grn}, 32'h0);
        check("t7_blu", {16'h0, sig_blu}, 32'h0);
        check("t7_cnt", {28'h0, sig_count}, 32'h0);
        check("t7_valid", {31'h0, sig_valid}, 32'h0);
        check("t7_ovf", {31'h0, sig_ovf}, 32'h0);
        check("t7_busy", {31'h0, busy}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
